iot_event_arbiter: RTL

- Sits between N IoT device-interface ports and the active-device `monitor` counter.
- Shares the monitor's single `change`/`on_off` input between requesters using a round-robin scheme.
- Tracks per-device on/off state, so only real transitions reach the counter. A redundant request (device already on asking for on) is acknowledged but never pulses `change`.
- Keeps the monitor count equal to the number of set bits in `active_mask`.

---
 rtl/iot_event_arbiter_pkg.sv | 20 ++
 rtl/iot_event_arbiter_rr_arbiter.sv | 36 +++
 rtl/iot_event_arbiter.sv | 94 +++++++++
 3 files changed

// File: rtl/iot_event_arbiter_pkg.sv
// Shared types and helpers for the IoT event arbiter: device count default,
// index-width helper and the grant FSM state encoding.
package iot_pkg;

  localparam int N_DEV_DEFAULT = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Width of a device index; never narrower than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/iot_event_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after
// (last_grant + 1) mod N_DEV.
module rr_arbiter
  import iot_pkg::*;
#(
  parameter  int N_DEV = N_DEV_DEFAULT,
  localparam int IDX_W = clog2(N_DEV)
) (
  input  logic [N_DEV-1:0] eligible,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_DEV-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  int               idx;
  logic [IDX_W-1:0] sel;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    sel         = '0;
    for (int k = 1; k <= N_DEV; k++) begin
      idx = (int'(last_grant) + k) % N_DEV;
      sel = IDX_W'(idx);
      if (!grant_valid && eligible[sel]) begin
        grant[sel]  = 1'b1;
        grant_idx   = sel;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iot_event_arbiter.sv
// Round-robin arbiter sharing the monitor's change/on_off input among N_DEV
// devices; tracks per-device state so only real transitions pulse change.
module iot_event_arbiter
  import iot_pkg::*;
#(
  parameter  int N_DEV = N_DEV_DEFAULT,
  localparam int IDX_W = clog2(N_DEV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DEV-1:0] req,
  input  logic [N_DEV-1:0] req_on,
  output logic [N_DEV-1:0] ack,
  output logic             change,
  output logic             on_off,
  output logic [N_DEV-1:0] active_mask,
  output logic             redundant
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [N_DEV-1:0] ack_q, ack_d;
  logic [N_DEV-1:0] active_mask_q, active_mask_d;
  logic             change_q, change_d;
  logic             on_off_q, on_off_d;
  logic             redundant_q, redundant_d;

  logic [N_DEV-1:0] ack_mask;
  logic [N_DEV-1:0] eligible;
  logic [N_DEV-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;

  // A device acked last cycle still shows req high for one cycle; mask it out.
  assign ack_mask = (state_q == GRANT) ? (N_DEV'(1) << last_grant_q) : '0;
  assign eligible = req & ~ack_mask;

  rr_arbiter #(.N_DEV(N_DEV)) u_rr (
    .eligible   (eligible),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
  );

  always_comb begin
    state_d       = IDLE;
    last_grant_d  = last_grant_q;
    ack_d         = '0;
    active_mask_d = active_mask_q;
    change_d      = 1'b0;
    on_off_d      = 1'b0;
    redundant_d   = 1'b0;
    if (grant_valid) begin
      state_d      = GRANT;
      last_grant_d = grant_idx;
      ack_d        = grant;
      if (req_on[grant_idx] != active_mask_q[grant_idx]) begin
        change_d                 = 1'b1;
        on_off_d                 = req_on[grant_idx];
        active_mask_d[grant_idx] = req_on[grant_idx];
      end else begin
        redundant_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= IDX_W'(N_DEV - 1);
      ack_q         <= '0;
      active_mask_q <= '0;
      change_q      <= 1'b0;
      on_off_q      <= 1'b0;
      redundant_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      ack_q         <= ack_d;
      active_mask_q <= active_mask_d;
      change_q      <= change_d;
      on_off_q      <= on_off_d;
      redundant_q   <= redundant_d;
    end
  end

  assign ack         = ack_q;
  assign change      = change_q;
  assign on_off      = on_off_q;
  assign active_mask = active_mask_q;
  assign redundant   = redundant_q;

endmodule
